ram_arbiter: RTL and testbench

- Shares one dual-address `ram` instance (one write port, one registered read port) among NUM_REQ requesters, e.g. label-equivalence and feature-accumulator stages.
- Runs two independent round-robin arbiters, one for the write channel and one for the read channel. One write and one read can therefore be granted in the same cycle.
- Returns read data to the granted requester with a per-requester valid strobe aligned to the RAM's 1-cycle read latency.

---
 rtl/ram_arbiter_pkg.sv | 40 ++++
 rtl/ram_arbiter_if.sv | 27 ++
 rtl/ram.sv | 24 ++
 rtl/ram_arbiter.sv | 107 ++++++++++
 tb/tb_ram_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared arbitration types and the round-robin picker used by both RAM channels.
// Latency: pure combinational helper, no state.
// Backpressure: none here; callers decide what a missing pick means.
package ram_arbiter_pkg;

    // Index width covers the largest legal requester count (16), so one package
    // serves every instance regardless of its NUM_REQ.
    localparam int MAX_REQ   = 16;
    localparam int IDX_WIDTH = $clog2(MAX_REQ);

    typedef struct packed {
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
    } rr_pick_t;

    // Round-robin select: first set bit of vec scanning upward from last+1,
    // wrapping at n. Only the low n bits of vec take part.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   vec,
        input logic [IDX_WIDTH-1:0] last,
        input int                   n
    );
        rr_pick_t p;
        int       pos;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            pos = int'(last) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((k <= n) && !p.found && vec[pos[IDX_WIDTH-1:0]]) begin
                p.found = 1'b1;
                p.idx   = pos[IDX_WIDTH-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the shared RAM arbiter.
// Latency: wires only; gnt is combinational, rvalid/rdata arrive one cycle after gnt.
// Backpressure: a requester holds req/we/addr/wdata until it sees its gnt bit.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          rw_collision;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, rw_collision
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, rw_collision
    );
endinterface

// File: rtl/ram.sv
// Simple dual-address RAM: one write port, one registered read port.
// Latency: read data appears one cycle after r_addr is sampled.
// Backpressure: none; a write and a read are accepted every cycle.
module ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write and read share the edge; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[w_addr] <= data_in;
        end
        data_out <= mem[r_addr];
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM among NUM_REQ requesters with independent write and read round-robin arbiters.
// Latency: grant combinational in the access cycle; rvalid/rdata one cycle after a read grant.
// Backpressure: losers are simply not granted and keep their request asserted.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4    // legal range 2..16
) (
    input  logic         clk,
    input  logic         reset_n,
    ram_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]    wr_cand;
    logic [NUM_REQ-1:0]    rd_cand;
    logic [NUM_REQ-1:0]    wr_gnt;
    logic [NUM_REQ-1:0]    rd_gnt;
    logic [NUM_REQ-1:0]    rvalid_dec;
    rr_pick_t              wr_pick;
    rr_pick_t              rd_pick;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    logic [IDX_WIDTH-1:0]  wr_last;
    logic [IDX_WIDTH-1:0]  rd_last;
    logic [IDX_WIDTH-1:0]  rd_owner;
    logic                  rd_pend;
    logic                  rw_coll_q;

    // Split requests into write/read classes, pick a winner per class and steer its address/data.
    always_comb begin
        wr_cand = bus.req & bus.we;
        rd_cand = bus.req & ~bus.we;
        wr_pick = rr_pick(MAX_REQ'(wr_cand), wr_last, NUM_REQ);
        rd_pick = rr_pick(MAX_REQ'(rd_cand), rd_last, NUM_REQ);
        // Grants are suppressed during reset so nothing reaches the RAM.
        wr_en   = wr_pick.found & reset_n;
        rd_en   = rd_pick.found & reset_n;
        wr_gnt  = '0;
        rd_gnt  = '0;
        w_addr  = '0;
        r_addr  = '0;
        data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_en && (wr_pick.idx == IDX_WIDTH'(i))) begin
                wr_gnt[i] = 1'b1;
                w_addr    = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                data_in   = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_en && (rd_pick.idx == IDX_WIDTH'(i))) begin
                rd_gnt[i] = 1'b1;
                r_addr    = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Pointer, read-owner and collision state; reset makes requester 0 top priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_last   <= IDX_WIDTH'(NUM_REQ - 1);
            rd_last   <= IDX_WIDTH'(NUM_REQ - 1);
            rd_owner  <= '0;
            rd_pend   <= 1'b0;
            rw_coll_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_last <= wr_pick.idx;
            end
            if (rd_en) begin
                rd_last  <= rd_pick.idx;
                rd_owner <= rd_pick.idx;
            end
            rd_pend   <= rd_en;
            rw_coll_q <= wr_en && rd_en && (w_addr == r_addr);
        end
    end

    // Expand the registered owner into the per-requester valid strobe.
    always_comb begin
        rvalid_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_dec[i] = rd_pend && (rd_owner == IDX_WIDTH'(i));
        end
    end

    assign bus.gnt          = wr_gnt | rd_gnt;
    assign bus.rvalid       = rvalid_dec;
    assign bus.rdata        = data_out;
    assign bus.rw_collision = rw_coll_q;

    ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) U0 (
        .clk      (clk),
        .wen      (wr_en),
        .w_addr   (w_addr),
        .data_in  (data_in),
        .r_addr   (r_addr),
        .data_out (data_out)
    );
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed cycles check gnt, a monitor checks read returns.
// Latency: expected reads are queued at grant and popped when rvalid appears a cycle later.
// Backpressure: the bench models requesters that change payload only after their grant.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 4;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
        bit            chk_data;
        bit            coll;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_len = 0;
    int   max_run = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Requesters must present a known type whenever they request.
    always @(negedge clk) begin
        if (reset_n) begin
            assert (!$isunknown(bus.we & bus.req))
                else $error("we unknown while req high");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
    endfunction

    // One access cycle: called at posedge+1, checks gnt mid-cycle, queues the read return.
    task automatic cyc(input string name, input logic [NR-1:0] r, input logic [NR-1:0] w,
                       input logic [NR-1:0] exp_gnt, input logic [DW-1:0] exp_data,
                       input bit chk_data, input bit exp_coll);
        exp_t e;
        bus.req = r;
        bus.we  = w;
        @(negedge clk);
        check({name, " gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        if ((exp_gnt & ~w) != '0) begin
            e.vld      = exp_gnt & ~w;
            e.data     = exp_data;
            e.chk_data = chk_data;
            e.coll     = exp_coll;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (bus.rvalid === 4'b0100) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.rvalid !== '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected rvalid: got %b expected none", bus.rvalid);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid", 32'(bus.rvalid), 32'(e.vld));
                    if (e.chk_data) check("rdata", bus.rdata, e.data);
                    check("rw_collision", 32'(bus.rw_collision), 32'(e.coll));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [NR-1:0] eg;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset: no grants, no valids; requests raised late must still be masked.
        for (int k = 0; k < 5; k++) begin
            if (k >= 3) bus.req = 4'b1111;
            @(negedge clk);
            check("reset gnt", 32'(bus.gnt), 32'h0);
            check("reset rvalid", 32'(bus.rvalid), 32'h0);
            check("reset rw_collision", 32'(bus.rw_collision), 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // All four reading: round-robin from requester 0.
        for (int k = 0; k < 5; k++) begin
            cyc("rr reads", 4'b1111, 4'b0000, 4'(1 << (k % 4)), '0, 1'b0, 1'b0);
        end

        // Write then read-back through a different requester.
        set_req(2, 8'h10, 32'hDEADBEEF);
        cyc("wr 0x10", 4'b0100, 4'b0100, 4'b0100, '0, 1'b0, 1'b0);
        set_req(1, 8'h10, '0);
        cyc("rd 0x10", 4'b0010, 4'b0000, 4'b0010, 32'hDEADBEEF, 1'b1, 1'b0);

        // Same-address read and write in one cycle returns old data and flags a collision.
        set_req(0, 8'h20, 32'h5);
        cyc("preload 0x20", 4'b0001, 4'b0001, 4'b0001, '0, 1'b0, 1'b0);
        set_req(0, 8'h20, 32'h1);
        set_req(3, 8'h20, '0);
        cyc("collide", 4'b1001, 4'b0001, 4'b1001, 32'h5, 1'b1, 1'b1);
        cyc("reread", 4'b1000, 4'b0000, 4'b1000, 32'h1, 1'b1, 1'b0);

        // Two continuous writers alternate starting with requester 1.
        d0 = 32'hA0;
        d1 = 32'hB0;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 8'h30, d0);
            set_req(1, 8'h31, d1);
            eg = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            cyc("alt writes", 4'b0011, 4'b0011, eg, '0, 1'b0, 1'b0);
            if (eg[1]) d1 = d1 + 1;
            else       d0 = d0 + 1;
        end
        set_req(0, 8'h30, '0);
        set_req(1, 8'h31, '0);
        cyc("rd 0x30", 4'b0001, 4'b0000, 4'b0001, 32'hA3, 1'b1, 1'b0);
        cyc("rd 0x31", 4'b0010, 4'b0000, 4'b0010, 32'hB3, 1'b1, 1'b0);

        // Reset pulse while a read return is pending.
        set_req(1, 8'h31, '0);
        bus.req = 4'b0010;
        bus.we  = 4'b0000;
        @(negedge clk);
        check("pre-reset gnt", 32'(bus.gnt), 32'h2);
        @(posedge clk);
        #1;
        check("pre-reset rvalid", 32'(bus.rvalid), 32'h2);
        reset_n = 1'b0;
        #1;
        check("async rvalid clear", 32'(bus.rvalid), 32'h0);
        check("gnt in reset", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        check("gnt held reset", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_req(2, 8'h30, '0);
        set_req(3, 8'h10, '0);
        cyc("post-reset first", 4'b1110, 4'b0000, 4'b0010, 32'hB3, 1'b1, 1'b0);
        cyc("post-reset second", 4'b1100, 4'b0000, 4'b0100, 32'hA3, 1'b1, 1'b0);
        cyc("post-reset third", 4'b1000, 4'b0000, 4'b1000, 32'hDEADBEEF, 1'b1, 1'b0);

        // Full-depth preload, then one requester streams every address back.
        for (int i = 0; i < 256; i++) begin
            set_req(0, 8'(i), pat(i));
            cyc("preload", 4'b0001, 4'b0001, 4'b0001, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 256; i++) begin
            set_req(2, 8'(i), '0);
            cyc("stream rd", 4'b0100, 4'b0000, 4'b0100, pat(i), 1'b1, 1'b0);
        end
        cyc("idle", 4'b0000, 4'b0000, 4'b0000, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #4;
        check("stream run length", 32'(max_run), 32'd256);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
